fizzbuzz_stream: RTL
====================

# fizzbuzz_stream

Sequential, parametrised FizzBuzz generator. On a start pulse it walks an inclusive range `first..last`. Each value is emitted as one beat on a valid/ready output stream, tagged with divisibility flags. Residues come from incremental modulo counters, so the datapath needs no divider. The block feeds downstream formatting/display logic and replaces the per-value combinational checker in streaming use.

## Interface
- `WIDTH`, 8: bit width of range bounds and emitted value.
- `FIZZ_DIV`, 3: fizz divisor; legal range 2..2^WIDTH-1.
- `BUZZ_DIV`, 5: buzz divisor; legal range 2..2^WIDTH-1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `first`  in  WIDTH  range start, sampled with `start`.
- `last`  in  WIDTH  range end (inclusive), sampled with `start`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts beat.
- `out_n`  out  WIDTH  current value.
- `out_fizz`  out  1  `out_n % FIZZ_DIV == 0`.
- `out_buzz`  out  1  `out_n % BUZZ_DIV == 0`.
- `out_kind`  out  2  `kind_t`: NUM=0, FIZZ=1, BUZZ=2, FIZZBUZZ=3.
- `out_last`  out  1  beat carries `out_n == last`.
- `busy`  out  1  high in RUN.
- `range_err`  out  1  one-cycle pulse: `start` rejected because `first > last`.

## Operation
- FSM `state_t`: IDLE, RUN.
- IDLE + `start` + `first <= last`:
  - latch `first`/`last`;
  - load residues `rf = first % FIZZ_DIV` and `rb = first % BUZZ_DIV` (constant-divisor modulo, evaluated only at load);
  - go to RUN.
- IDLE + `start` + `first > last`: pulse `range_err`, stay IDLE, emit nothing.
- RUN: `out_valid = 1`.
  - Transfer = `out_valid & out_ready`.
  - On transfer with `out_n != last`: `out_n += 1`. Each residue advances: `r = (r == DIV-1) ? 0 : r+1`.
  - On transfer with `out_n == last`: go to IDLE. `out_n` is never incremented past `last`, so `last = 2^WIDTH-1` causes no wrap.
- Flags: `out_fizz = (rf == 0)`, `out_buzz = (rb == 0)`. `out_kind = {out_buzz, out_fizz}`. `out_last = (out_n == last)`.
- Value 0 is divisible by both divisors: kind FIZZBUZZ.
- `start` in RUN is ignored; no queuing.
- Reset values: state IDLE, `out_valid` 0, `busy` 0, `range_err` 0, `out_n` 0, residues 0, `out_last` 0.

## Timing
- `start` sampled at edge t → `out_valid` = 1 and `out_n = first` from cycle t+1.
- Throughput: one beat per cycle while `out_ready` is held high.
- Stall (`out_valid & !out_ready`): `out_n`, flags, `out_kind` and `out_last` hold stable; AXI-style, valid never drops without a transfer.
- Last transfer at edge t → IDLE at t+1. A new `start` is accepted at t+1, and its first beat appears at t+2.
- Run length is `last - first + 1` beats. A single-value run (`first == last`) is one beat with `out_last = 1`.
- `range_err` is asserted the cycle after `start` is sampled.
- `rst` mid-run: `out_valid` and `busy` are 0 the cycle after `rst` is sampled. The in-flight beat is dropped; no partial state is retained.
- `rst` has priority over `start` in the same cycle.

## Structure
- Package `fizzbuzz_pkg`: `kind_t` enum (NUM, FIZZ, BUZZ, FIZZBUZZ), `state_t` enum (IDLE, RUN), and a helper function computing the residue width `$clog2(DIV)`.
- Sub-module `mod_counter`, parameters `WIDTH`, `DIV`. Ports: `clk`, `rst`, `load`, `load_val` (WIDTH), `adv`, `res`, `zero`.
  - On `load`: `res = load_val % DIV`.
  - On `adv`: residue increments with wrap at `DIV`.
- `mod_counter` is instantiated twice, once for fizz and once for buzz.
- Elaboration-time check: each DIV is in 2..2^WIDTH-1.

## Test plan
- Default params, `first=1`, `last=15`, `out_ready=1`:
  - 15 consecutive beats, `out_kind` = NUM,NUM,FIZZ,NUM,BUZZ,FIZZ,NUM,NUM,FIZZ,BUZZ,NUM,FIZZ,NUM,NUM,FIZZBUZZ;
  - `out_last` only on `n=15`;
  - `busy` low the cycle after.
- `first=28`, `last=31`, `out_ready` toggled 1,0,0,1,0,1…:
  - during stalls, beat fields are stable;
  - exactly 4 transfers with n=28,29,30,31;
  - n=30 is FIZZBUZZ.
- `first=250`, `last=255`, `WIDTH=8`: beats 250..255 with no wrap to 0; 252 and 255 are FIZZ; 250 and 255 are BUZZ.
- `start` with `first=9`, `last=4`: `range_err` pulses one cycle, `out_valid` stays 0. A second `start` issued during a 1..15 run is ignored, and the run completes unchanged.
- `rst` asserted after the 3rd transfer of 1..15: `out_valid` is 0 the next cycle. A new run with `first=0`, `last=0` then emits a single beat: n=0, FIZZBUZZ, `out_last` = 1.
- `FIZZ_DIV=7`, `BUZZ_DIV=11`, `WIDTH=10`, run 1..100 with random `out_ready`: every beat matches a `%` reference model, and exactly 100 transfers occur.

Source files
------------

// File: rtl/fizzbuzz_pkg.sv
// Shared types for the FizzBuzz stream generator: beat classification,
// controller states, and residue-width sizing.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    NUM      = 2'd0,
    FIZZ     = 2'd1,
    BUZZ     = 2'd2,
    FIZZBUZZ = 2'd3
  } kind_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int res_width(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/fizzbuzz_stream_mod_counter.sv
// Incremental residue tracker: loads value % DIV once, then steps with wrap.
// Updates one cycle after load/adv; no flow control of its own.
module mod_counter
  import fizzbuzz_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_val,
  input  logic                      adv,
  output logic [res_width(DIV)-1:0] res,
  output logic                      zero
);

  localparam int RW = res_width(DIV);
  localparam logic [RW-1:0] RES_TOP = RW'(DIV - 1);

  generate
    if (DIV < 2 || DIV > (2 ** WIDTH) - 1) begin : g_bad_div
      $error("mod_counter: DIV must lie in 2..2^WIDTH-1");
    end
  endgenerate

  // The modulo is by a constant and only used on load, so no runtime divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (load) begin
      res <= RW'(32'(load_val) % DIV);
    end else if (adv) begin
      res <= (res == RES_TOP) ? '0 : res + 1'b1;
    end
  end

  assign zero = (res == '0);

endmodule

// File: rtl/fizzbuzz_stream.sv
// Walks first..last emitting one tagged beat per accepted transfer; first beat
// one cycle after start, holds stable under out_ready stalls.
module fizzbuzz_stream
  import fizzbuzz_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FIZZ_DIV = 3,
  parameter int BUZZ_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_n,
  output logic             out_fizz,
  output logic             out_buzz,
  output logic [1:0]       out_kind,
  output logic             out_last,
  output logic             busy,
  output logic             range_err
);

  state_t state, state_nx;
  logic [WIDTH-1:0] n_q, last_q;
  logic range_err_q;
  logic xfer, at_last, load, reject, adv;
  logic fizz_zero, buzz_zero;
  logic [res_width(FIZZ_DIV)-1:0] fizz_res;
  logic [res_width(BUZZ_DIV)-1:0] buzz_res;
  logic unused_res;
  kind_t kind;

  assign at_last = (n_q == last_q);
  assign xfer    = out_valid & out_ready;
  assign load    = (state == IDLE) & start & (first <= last);
  assign reject  = (state == IDLE) & start & (first > last);
  // Residues freeze on the final beat so they never step past last.
  assign adv     = xfer & ~at_last;
  assign unused_res = ^{fizz_res, buzz_res};

  mod_counter #(.WIDTH(WIDTH), .DIV(FIZZ_DIV)) u_fizz (
    .clk(clk), .rst(rst), .load(load), .load_val(first), .adv(adv),
    .res(fizz_res), .zero(fizz_zero)
  );

  mod_counter #(.WIDTH(WIDTH), .DIV(BUZZ_DIV)) u_buzz (
    .clk(clk), .rst(rst), .load(load), .load_val(first), .adv(adv),
    .res(buzz_res), .zero(buzz_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n_q         <= '0;
      last_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      range_err_q <= reject;
      if (load) begin
        n_q    <= first;
        last_q <= last;
      end else if (adv) begin
        n_q <= n_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = RUN;
      RUN:     if (xfer && at_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == RUN);
    busy      = (state == RUN);
    out_n     = n_q;
    out_fizz  = fizz_zero;
    out_buzz  = buzz_zero;
    kind      = kind_t'({buzz_zero, fizz_zero});
    out_kind  = kind;
    out_last  = (state == RUN) & at_last;
    range_err = range_err_q;
  end

endmodule
